// File: rtl/icache_param.sv
// icache_param: set-associative read-only instruction cache with tree PLRU and sequenced flush.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_param #(
    parameter int WAYS       = 4,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            cpu_addr_in,
    input  logic                   cpu_req_in,
    input  logic                   cpu_flush_in,
    output logic [31:0]            cpu_data_out,
    output logic                   cpu_ready_out,
    output logic                   mem_req_out,
    output logic [31:0]            mem_addr_out,
    input  logic [LINE_WORDS*32-1:0] mem_data_in,
    input  logic                   mem_ready_in,
    output logic [31:0]            perf_hit_out,
    output logic [31:0]            perf_miss_out
);
    localparam int OFF = $clog2(LINE_WORDS * 4);
    localparam int IB  = $clog2(SETS);
    localparam int VB  = $clog2(WAYS);
    localparam int TW  = 32 - OFF - IB;
    localparam int LW  = LINE_WORDS * 32;
    localparam logic [1:0] IDLE = 2'd0, REFILL = 2'd1, FLUSH = 2'd2;

    logic [1:0]      state_q;
    logic [TW-1:0]   tag_q  [SETS][WAYS];
    logic [LW-1:0]   line_q [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];
    logic [31:0]     addr_q;
    logic [VB-1:0]   victim_q, victim, hit_way;
    logic [IB-1:0]   fl_q, idx, fidx;
    logic [TW-1:0]   tag, ftag;
    logic [OFF-3:0]  wsel;
    logic            pend_q, hit, miss_go, unused_ok;

    assign idx  = cpu_addr_in[OFF+IB-1:OFF];
    assign tag  = cpu_addr_in[31:OFF+IB];
    assign wsel = cpu_addr_in[OFF-1:2];
    assign fidx = addr_q[OFF+IB-1:OFF];
    assign ftag = addr_q[31:OFF+IB];
    assign unused_ok = ^cpu_addr_in[1:0];

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic logic [VB-1:0] plru_victim(input logic [WAYS-2:0] b);
        int n;
        logic [VB-1:0] v;
        n = 0;
        v = '0;
        for (int l = 0; l < VB; l++) begin
            v[VB-1-l] = b[n[VB-1:0]];
            n = 2 * n + 1 + int'(v[VB-1-l]);
        end
        return v;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b, input logic [VB-1:0] w);
        int n;
        n = 0;
        for (int l = 0; l < VB; l++) begin
            b[n[VB-1:0]] = ~w[VB-1-l];
            n = 2 * n + 1 + int'(w[VB-1-l]);
        end
        return b;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = VB'(w);
            end
    end

    always_comb begin
        victim = plru_victim(plru_q[idx]);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[idx][w]) victim = VB'(w);
    end

    assign cpu_ready_out = state_q == IDLE && cpu_req_in && hit;
    assign cpu_data_out  = cpu_ready_out ? line_q[idx][hit_way][{wsel, 5'd0} +: 32] : '0;
    assign mem_req_out   = state_q == REFILL;
    assign mem_addr_out  = addr_q;
    assign miss_go       = state_q == IDLE && cpu_req_in && !hit && !cpu_flush_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            pend_q   <= 1'b0;
            fl_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_ready_out) plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                    if (cpu_flush_in) state_q <= FLUSH;
                    if (miss_go) begin
                        state_q  <= REFILL;
                        addr_q   <= {cpu_addr_in[31:OFF], {OFF{1'b0}}};
                        victim_q <= victim;
                    end
                end
                REFILL: begin
                    if (cpu_flush_in) pend_q <= 1'b1;
                    if (mem_ready_in) begin
                        valid_q[fidx][victim_q] <= 1'b1;
                        plru_q[fidx]            <= plru_touch(plru_q[fidx], victim_q);
                        pend_q                  <= 1'b0;
                        state_q                 <= (pend_q || cpu_flush_in) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    valid_q[fl_q] <= '0;
                    plru_q[fl_q]  <= '0;
                    fl_q          <= fl_q + 1'b1;
                    if (fl_q == IB'(SETS - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line and tag storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_ready_in) begin
            line_q[fidx][victim_q] <= mem_data_in;
            tag_q[fidx][victim_q]  <= ftag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cpu_ready_out) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (miss_go) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end
    assign perf_hit_out  = hit_cnt_q;
    assign perf_miss_out = miss_cnt_q;
`else
    assign perf_hit_out  = '0;
    assign perf_miss_out = '0;
`endif
endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: directed self-checking bench for icache_param (4 ways, 32 sets, 8-word lines).
module tb_icache_param;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   cpu_addr = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_flush = 1'b0;
    logic [31:0]   cpu_data_out;
    logic          cpu_ready_out;
    logic          mem_req_out;
    logic [31:0]   mem_addr_out;
    logic [LW-1:0] mem_data = '0;
    logic          mem_ready = 1'b0;
    logic [31:0]   perf_hit_out, perf_miss_out;
    int            checks = 0;
    int            errors = 0;
    int            n;

    icache_param #(.WAYS(4), .SETS(32), .LINE_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr_in(cpu_addr), .cpu_req_in(cpu_req), .cpu_flush_in(cpu_flush),
        .cpu_data_out(cpu_data_out), .cpu_ready_out(cpu_ready_out),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_data_in(mem_data), .mem_ready_in(mem_ready),
        .perf_hit_out(perf_hit_out), .perf_miss_out(perf_miss_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Line whose word i holds seed+i.
    function automatic logic [LW-1:0] mk(input logic [31:0] seed);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + 32'(i);
        return l;
    endfunction

    task automatic req(input logic [31:0] a);
        cpu_addr = a;
        cpu_req  = 1'b1;
        #1;
    endtask

    task automatic refill(input string tag, input logic [31:0] a, input logic [LW-1:0] line, input int dly);
        int k;
        k = 0;
        while (!mem_req_out && k < 20) begin
            cyc();
            k++;
        end
        chk({tag, "_req"}, 32'(mem_req_out), 32'd1);
        chk({tag, "_maddr"}, mem_addr_out, {a[31:5], 5'd0});
        repeat (dly) cyc();
        mem_data  = line;
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req(a);
        chk({tag, "_rdy"}, 32'(cpu_ready_out), 32'd1);
        chk({tag, "_dat"}, cpu_data_out, exp);
        chk({tag, "_nomem"}, 32'(mem_req_out), 32'd0);
        cyc();
    endtask

    task automatic miss(input string tag, input logic [31:0] a, input logic [31:0] seed);
        req(a);
        chk({tag, "_miss"}, 32'(cpu_ready_out), 32'd0);
        refill(tag, a, mk(seed), 2);
        chk({tag, "_rdy"}, 32'(cpu_ready_out), 32'd1);
        chk({tag, "_dat"}, cpu_data_out, seed + 32'(a[4:2]));
        cyc();
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_rdy", 32'(cpu_ready_out), 32'd0);
        chk("rst_dat", cpu_data_out, 32'd0);
        chk("rst_mreq", 32'(mem_req_out), 32'd0);
        chk("rst_maddr", mem_addr_out, 32'd0);
        chk("rst_phit", perf_hit_out, 32'd0);
        chk("rst_pmiss", perf_miss_out, 32'd0);
        rst_n = 1'b1;
        cyc();

        req(32'h0000_1024);
        chk("cold_miss", 32'(cpu_ready_out), 32'd0);
        refill("cold", 32'h0000_1024, mk(32'hA0), 4);
        chk("cold_rdy", 32'(cpu_ready_out), 32'd1);
        chk("cold_dat", cpu_data_out, 32'hA1);
        chk("cold_mreq_off", 32'(mem_req_out), 32'd0);
        cyc();
        expect_hit("hit7", 32'h0000_103C, 32'hA7);
        cpu_req = 1'b0;

        req(32'h0000_4000);
        cyc();
        chk("fl_mreq", 32'(mem_req_out), 32'd1);
        cpu_flush = 1'b1;
        cyc();
        cpu_flush = 1'b0;
        repeat (2) cyc();
        mem_data  = mk(32'h4000);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cpu_addr  = 32'h0000_1024;
        #1;
        n = 0;
        while (!mem_req_out && n < 100) begin
            n++;
            cyc();
        end
        chk("flush_len", 32'(n), 32'd33);
        refill("refl", 32'h0000_1024, mk(32'hA0), 1);
        chk("refl_dat", cpu_data_out, 32'hA1);
        cyc();

        miss("t1", 32'h0000_2020, 32'h2020);
        miss("t2", 32'h0000_2420, 32'h2420);
        miss("t3", 32'h0000_2820, 32'h2820);
        expect_hit("t0a", 32'h0000_1020, 32'hA0);
        miss("t4", 32'h0000_2C20, 32'h2C20);
        expect_hit("t0b", 32'h0000_1020, 32'hA0);
        expect_hit("t1b", 32'h0000_2020, 32'h2020);
        expect_hit("t3b", 32'h0000_2820, 32'h2820);
        expect_hit("t4b", 32'h0000_2C20, 32'h2C20);
        miss("t2evict", 32'h0000_2420, 32'h2420);
        cpu_req = 1'b0;
        cyc();

        req(32'h0000_5000);
        cyc();
        chk("rr_mreq", 32'(mem_req_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_mreq_drop", 32'(mem_req_out), 32'd0);
        chk("rr_rdy", 32'(cpu_ready_out), 32'd0);
        cpu_req = 1'b0;
        cyc();
        rst_n     = 1'b1;
        mem_data  = mk(32'h5000);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("rr_stray", 32'(mem_req_out), 32'd0);
        cyc();
        miss("rr_again", 32'h0000_5000, 32'h5000);
        cpu_req = 1'b0;

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        miss("p0", 32'h0000_6000, 32'h6000);
        miss("p1", 32'h0000_6020, 32'h6020);
        miss("p2", 32'h0000_6040, 32'h6040);
        for (int i = 0; i < 7; i++)
            expect_hit("ph", 32'h0000_6000 + 32'(i * 4), 32'h6000 + 32'(i));
        cpu_req = 1'b0;
        #1;
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit", perf_hit_out, 32'd10);
        chk("perf_miss", perf_miss_out, 32'd3);
`else
        chk("perf_hit", perf_hit_out, 32'd0);
        chk("perf_miss", perf_miss_out, 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
